// File: rtl/trig_hit_packer_if.sv
// trig_hit_packer_if: column trigger-hit bus in, formatted trigger word out.
interface trig_hit_packer_if #(
    parameter int unsigned NCOL = 16
);
    logic [8*NCOL-1:0] trigHitsIn;
    logic [7:0]        trigData;
    logic              trigIsSync;
    logic [11:0]       bcCnt;

    // Column trigger stage / serializer side
    modport master (
        output trigHitsIn,
        input  trigData,
        input  trigIsSync,
        input  bcCnt
    );

    // Packer side
    modport slave (
        input  trigHitsIn,
        output trigData,
        output trigIsSync,
        output bcCnt
    );
endinterface

// File: rtl/trig_hit_packer.sv
// trig_hit_packer: ORs each trigger-hit line across all columns, reduces the
// result to a 0/1/2/4/8-bit trigger word per BC and inserts link alignment
// words (after reset, on syncReq, and at one programmable BC per orbit).
// Optional feature macro: TRIG_HIT_COUNT_EN (adds hitCntClr/hitCnt hit-word counter).
module trig_hit_packer #(
    parameter int unsigned NCOL        = 16,
    parameter int unsigned ORBIT_LEN   = 3564,
    parameter int unsigned SYNC_CYCLES = 32,
    parameter logic [7:0]  SYNC_WORD   = 8'h5C
) (
    input  logic              clk,
    input  logic              reset,
    trig_hit_packer_if.slave  bus,
    input  logic [2:0]        trigDataSize,
    input  logic [11:0]       emptySlotBC,
    input  logic              bcr,
    input  logic              syncReq
`ifdef TRIG_HIT_COUNT_EN
    ,
    input  logic              hitCntClr,
    output logic [15:0]       hitCnt
`endif
);
    localparam int unsigned BC_W = 12;
    localparam int unsigned SC_W = $clog2(SYNC_CYCLES + 1);

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [7:0]      lines_d, lines_q;
    logic [BC_W-1:0] bc_d, bc_q;
    logic [BC_W-1:0] bc_s1_q, bc_out_q;
    logic [7:0]      data_word;
    logic [7:0]      trig_data_d, trig_data_q;
    logic            is_sync_d, is_sync_q;
    logic            empty_slot;

    // OR each of the 8 trigger lines across all columns
    always_comb begin
        lines_d = '0;
        for (int c = 0; c < NCOL; c++) begin
            lines_d = lines_d | bus.trigHitsIn[8*c +: 8];
        end
    end

    // BC counter: free-running with orbit wrap; bcr overrides the wrap
    always_comb begin
        bc_d = bc_q + BC_W'(1);
        if (bcr || bc_q == BC_W'(ORBIT_LEN - 1)) begin
            bc_d = '0;
        end
    end

    // Reduce the stage-1 lines to the configured trigger word width
    always_comb begin
        data_word = '0;
        case (trigDataSize)
            3'd1:    data_word = {7'b0, |lines_q};
            3'd2:    data_word = {6'b0, |lines_q[7:4], |lines_q[3:0]};
            3'd3:    data_word = {4'b0, lines_q[7] | lines_q[6], lines_q[5] | lines_q[4],
                                  lines_q[3] | lines_q[2], lines_q[1] | lines_q[0]};
            3'd4:    data_word = lines_q;
            default: data_word = '0;
        endcase
    end

    // The word being formatted carries the BC tag held in bc_s1_q
    assign empty_slot = (bc_s1_q == emptySlotBC);

    // Next-state and stage-2 word selection (sync words vs. data words)
    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        trig_data_d = data_word;
        is_sync_d   = 1'b0;
        if (state_q == ST_SYNC) begin
            trig_data_d = SYNC_WORD;
            is_sync_d   = 1'b1;
            if (sync_cnt_q == SC_W'(SYNC_CYCLES - 1)) begin
                state_d    = ST_RUN;
                sync_cnt_d = '0;
            end else begin
                sync_cnt_d = sync_cnt_q + SC_W'(1);
            end
        end else if (empty_slot) begin
            trig_data_d = SYNC_WORD;
            is_sync_d   = 1'b1;
        end
        if (syncReq) begin
            state_d    = ST_SYNC;
            sync_cnt_d = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SYNC;
            sync_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    // Two-stage datapath; the BC tag travels alongside the data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_q     <= '0;
            bc_q        <= '0;
            bc_s1_q     <= '0;
            bc_out_q    <= '0;
            trig_data_q <= '0;
            is_sync_q   <= 1'b0;
        end else begin
            lines_q     <= lines_d;
            bc_q        <= bc_d;
            bc_s1_q     <= bc_q;
            bc_out_q    <= bc_s1_q;
            trig_data_q <= trig_data_d;
            is_sync_q   <= is_sync_d;
        end
    end

    assign bus.trigData   = trig_data_q;
    assign bus.trigIsSync = is_sync_q;
    assign bus.bcCnt      = bc_out_q;

`ifdef TRIG_HIT_COUNT_EN
    logic [15:0] hit_cnt_d, hit_cnt_q;

    // Count RUN data words with any line set; saturating, clear has priority
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (hitCntClr) begin
            hit_cnt_d = '0;
        end else if (state_q == ST_RUN && !empty_slot && (|lines_q) && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'(1);
        end
    end

    // Hit counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hitCnt = hit_cnt_q;
`endif
endmodule

// File: tb/tb_trig_hit_packer.sv
// tb_trig_hit_packer: directed vectors with hand-computed expectations.
module tb_trig_hit_packer;
    localparam int unsigned NCOL = 16;
    localparam int unsigned HW   = 8 * NCOL;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    trigDataSize;
    logic [11:0]   emptySlotBC;
    logic          bcr;
    logic          syncReq;
`ifdef TRIG_HIT_COUNT_EN
    logic          hitCntClr;
    logic [15:0]   hitCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    trig_hit_packer_if #(.NCOL(NCOL)) bus ();

    trig_hit_packer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .trigDataSize (trigDataSize),
        .emptySlotBC  (emptySlotBC),
        .bcr          (bcr),
        .syncReq      (syncReq)
`ifdef TRIG_HIT_COUNT_EN
        ,
        .hitCntClr    (hitCntClr),
        .hitCnt       (hitCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle hit pulse; word must appear exactly two edges later
    task automatic send_hit(input string tag, input logic [HW-1:0] hits,
                            input logic [2:0] size, input logic [7:0] exp);
        @(negedge clk);
        trigDataSize   = size;
        bus.trigHitsIn = hits;
        @(negedge clk);
        check({tag, "_lat"}, 32'(bus.trigData), 32'h0);
        bus.trigHitsIn = '0;
        @(negedge clk);
        check(tag, 32'(bus.trigData), 32'(exp));
        check({tag, "_sync"}, 32'(bus.trigIsSync), 32'h0);
    endtask

    // 32 alignment words followed by an idle data word
    task automatic sync_seq(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check({tag, "_word"}, 32'(bus.trigData), 32'h5C);
            check({tag, "_flag"}, 32'(bus.trigIsSync), 32'h1);
        end
        @(negedge clk);
        check({tag, "_end_data"}, 32'(bus.trigData), 32'h0);
        check({tag, "_end_flag"}, 32'(bus.trigIsSync), 32'h0);
    endtask

    // Bounded wait for a given output bcCnt value
    task automatic wait_bc(input string tag, input logic [11:0] target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (bus.bcCnt == target) found = 1'b1;
        end
        check({tag, "_reached"}, 32'(found), 32'h1);
    endtask

    logic [2:0] sz_tab [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    logic [7:0] ex_tab [6] = '{8'h81, 8'h09, 8'h03, 8'h01, 8'h00, 8'h00};

    initial begin
        logic [HW-1:0] h07;
        logic [HW-1:0] h23;
        reset          = 1'b1;
        trigDataSize   = 3'd4;
        emptySlotBC    = 12'd4000;
        bcr            = 1'b0;
        syncReq        = 1'b0;
        bus.trigHitsIn = '0;
`ifdef TRIG_HIT_COUNT_EN
        hitCntClr      = 1'b0;
`endif
        h07 = (HW'(1) << 0) | (HW'(1) << (8*9 + 7));
        h23 = (HW'(1) << (8*15 + 2)) | (HW'(1) << (8*4 + 3));

        // Reset state and first alignment sequence
        repeat (2) @(negedge clk);
        check("rst_data", 32'(bus.trigData), 32'h0);
        check("rst_sync", 32'(bus.trigIsSync), 32'h0);
        check("rst_bc", 32'(bus.bcCnt), 32'h0);
`ifdef TRIG_HIT_COUNT_EN
        check("rst_hitcnt", 32'(hitCnt), 32'h0);
`endif
        reset = 1'b0;
        sync_seq("boot");
        check("boot_bc", 32'(bus.bcCnt), 32'd31);

        // Column 3 line 5
        send_hit("c3l5_8b", HW'(1) << (8*3 + 5), 3'd4, 8'h20);
        send_hit("c3l5_1b", HW'(1) << (8*3 + 5), 3'd1, 8'h01);

        // Lines 0 and 7 from different columns, all sizes
        for (int k = 0; k < 6; k++) begin
            send_hit($sformatf("l07_sz%0d", sz_tab[k]), h07, sz_tab[k], ex_tab[k]);
        end
        send_hit("l23_4b", h23, 3'd3, 8'h02);
        send_hit("l23_2b", h23, 3'd2, 8'h01);

        // Empty slot at BC 100 with continuous hits
        trigDataSize   = 3'd4;
        emptySlotBC    = 12'd100;
        bus.trigHitsIn = HW'(1) << 1;
        wait_bc("es", 12'd99);
        check("es99_data", 32'(bus.trigData), 32'h02);
        check("es99_sync", 32'(bus.trigIsSync), 32'h0);
        @(negedge clk);
        check("es100_bc", 32'(bus.bcCnt), 32'd100);
        check("es100_data", 32'(bus.trigData), 32'h5C);
        check("es100_sync", 32'(bus.trigIsSync), 32'h1);
        @(negedge clk);
        check("es101_bc", 32'(bus.bcCnt), 32'd101);
        check("es101_data", 32'(bus.trigData), 32'h02);
        check("es101_sync", 32'(bus.trigIsSync), 32'h0);
        bus.trigHitsIn = '0;
        emptySlotBC    = 12'd4000;

        // bcr at tagged BC 3000: two words already in flight, then 0,1,2
        wait_bc("bcr", 12'd3000);
        bcr = 1'b1;
        @(negedge clk);
        bcr = 1'b0;
        check("bcr_a", 32'(bus.bcCnt), 32'd3001);
        @(negedge clk);
        check("bcr_b", 32'(bus.bcCnt), 32'd3002);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bcr_after", 32'(bus.bcCnt), 32'(k));
        end

        // Natural orbit wrap
        wait_bc("wrap", 12'd3562);
        @(negedge clk);
        check("wrap_last", 32'(bus.bcCnt), 32'd3563);
        @(negedge clk);
        check("wrap_zero", 32'(bus.bcCnt), 32'd0);
        @(negedge clk);
        check("wrap_one", 32'(bus.bcCnt), 32'd1);

        // syncReq mid-RUN
        syncReq = 1'b1;
        @(negedge clk);
        syncReq = 1'b0;
        check("sreq_edge_sync", 32'(bus.trigIsSync), 32'h0);
        sync_seq("sreq");

        // Reset mid-SYNC
        syncReq = 1'b1;
        @(negedge clk);
        syncReq = 1'b0;
        repeat (10) @(negedge clk);
        check("midsync_flag", 32'(bus.trigIsSync), 32'h1);
        reset = 1'b1;
        #1;
        check("arst_data", 32'(bus.trigData), 32'h0);
        check("arst_sync", 32'(bus.trigIsSync), 32'h0);
        check("arst_bc", 32'(bus.bcCnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sync_seq("rst2");

`ifdef TRIG_HIT_COUNT_EN
        // Five hit words, counted regardless of trigDataSize
        check("hc_start", 32'(hitCnt), 32'h0);
        @(negedge clk);
        trigDataSize   = 3'd0;
        bus.trigHitsIn = HW'(1) << 50;
        repeat (5) @(negedge clk);
        bus.trigHitsIn = '0;
        repeat (2) @(negedge clk);
        check("hc_five", 32'(hitCnt), 32'd5);
        // Clear coinciding with a counted hit word
        bus.trigHitsIn = HW'(1) << 50;
        @(negedge clk);
        bus.trigHitsIn = '0;
        hitCntClr      = 1'b1;
        @(negedge clk);
        hitCntClr      = 1'b0;
        check("hc_clr", 32'(hitCnt), 32'h0);
        @(negedge clk);
        check("hc_clr_hold", 32'(hitCnt), 32'h0);
        bus.trigHitsIn = HW'(1) << 7;
        @(negedge clk);
        bus.trigHitsIn = '0;
        repeat (2) @(negedge clk);
        check("hc_resume", 32'(hitCnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
